// File: rtl/goertzel_multibin.sv
// goertzel_multibin: time-multiplexed Goertzel engine covering NUM_BINS bins
// over a block of N = 2^log_n real samples. One shared multiplier path walks
// the bins after every accepted sample; results leave one bin per handshake.
// Ports:
//   i_sys_clk / i_sys_rst      clock, synchronous active-high reset
//   i_start, i_log_n, i_mode   block start, log2 block length, 0=power 1=raw
//   i_coef_we/addr/data        per-bin coefficient write (IDLE only)
//   i_x, i_x_valid, o_x_ready  sample stream in
//   o_y, o_y_valid, i_y_ready  result stream out, with o_bin / o_last
//   o_busy, o_done             not-IDLE flag, end-of-block pulse
module goertzel_multibin #(
  parameter int WIDTH      = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int COEF_WIDTH = 18,
  parameter int FRAC_BITS  = 14,
  parameter int NUM_BINS   = 8,
  parameter int N_MAX      = 32768,
  localparam int LOG_N_MAX = $clog2(N_MAX),
  localparam int LNW       = $clog2(LOG_N_MAX + 1),
  localparam int BW        = $clog2(NUM_BINS)
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_start,
  input  logic [LNW-1:0]         i_log_n,
  input  logic                   i_mode,
  input  logic                   i_coef_we,
  input  logic [BW-1:0]          i_coef_addr,
  input  logic [COEF_WIDTH-1:0]  i_coef_data,
  input  logic [WIDTH-1:0]       i_x,
  input  logic                   i_x_valid,
  output logic                   o_x_ready,
  output logic [2*ACC_WIDTH-1:0] o_y,
  output logic                   o_y_valid,
  input  logic                   i_y_ready,
  output logic [BW-1:0]          o_bin,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int CW = LOG_N_MAX + 1;            // sample count up to N_MAX
  localparam int PW = ACC_WIDTH + COEF_WIDTH;   // full coef*state product
  localparam int YW = 2 * ACC_WIDTH;

  typedef enum logic [2:0] {IDLE, ACCUM, SWEEP, OUT_CALC, OUT_HOLD} state_t;

  state_t state_q, state_d;

  logic signed [COEF_WIDTH-1:0] coef_q [NUM_BINS];
  logic signed [ACC_WIDTH-1:0]  s1_q   [NUM_BINS];
  logic signed [ACC_WIDTH-1:0]  s2_q   [NUM_BINS];
  logic signed [ACC_WIDTH-1:0]  x_q;
  logic [BW-1:0]                bin_q;
  logic [CW-1:0]                cnt_q;
  logic [LNW-1:0]               log_n_q;
  logic                         mode_q;
  logic [YW-1:0]                y_q;
  logic                         done_q;

  // Shared datapath, always operating on the bin selected by bin_q.
  logic signed [COEF_WIDTH-1:0] c_sel;
  logic signed [ACC_WIDTH-1:0]  s1_sel, s2_sel, t, s0;
  logic signed [PW-1:0]         prod;
  logic signed [YW-1:0]         pow;
  logic [LNW-1:0]               log_n_clamp;
  logic                         last_bin, blk_end;

  assign c_sel  = coef_q[bin_q];
  assign s1_sel = s1_q[bin_q];
  assign s2_sel = s2_q[bin_q];
  assign prod   = PW'(c_sel) * PW'(s1_sel);
  assign t      = ACC_WIDTH'(prod >>> FRAC_BITS);  // floor shift, then wrap
  assign s0     = x_q + t - s2_sel;
  assign pow    = YW'(s1_sel) * YW'(s1_sel) + YW'(s2_sel) * YW'(s2_sel)
                - YW'(t) * YW'(s2_sel);

  // Compare one bit wider so the clamp stays meaningful for any N_MAX.
  assign log_n_clamp = ({1'b0, i_log_n} > (LNW+1)'(LOG_N_MAX)) ? LNW'(LOG_N_MAX) : i_log_n;
  assign last_bin    = (bin_q == BW'(NUM_BINS - 1));
  assign blk_end     = ((cnt_q + CW'(1)) == (CW'(1) << log_n_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start)   state_d = ACCUM;
      ACCUM:    if (i_x_valid) state_d = SWEEP;
      SWEEP:    if (last_bin)  state_d = blk_end ? OUT_CALC : ACCUM;
      OUT_CALC:                state_d = OUT_HOLD;
      OUT_HOLD: if (i_y_ready) state_d = last_bin ? IDLE : OUT_CALC;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_BINS; i++) begin
        coef_q[i] <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
      x_q     <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      log_n_q <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write and start in one cycle: the new coefficient is in place
          // well before the first sweep reads it.
          if (i_coef_we) coef_q[i_coef_addr] <= i_coef_data;
          if (i_start) begin
            log_n_q <= log_n_clamp;
            mode_q  <= i_mode;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
              s1_q[i] <= '0;
              s2_q[i] <= '0;
            end
          end
        end
        ACCUM: if (i_x_valid) begin
          x_q   <= ACC_WIDTH'($signed(i_x));
          bin_q <= '0;
        end
        SWEEP: begin
          s1_q[bin_q] <= s0;
          s2_q[bin_q] <= s1_sel;
          if (last_bin) begin
            cnt_q <= cnt_q + CW'(1);
            bin_q <= '0;
          end else begin
            bin_q <= bin_q + BW'(1);
          end
        end
        OUT_CALC: y_q <= mode_q ? {s1_sel, s2_sel} : pow;
        OUT_HOLD: if (i_y_ready) begin
          if (last_bin) done_q <= 1'b1;
          else          bin_q  <= bin_q + BW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_x_ready = (state_q == ACCUM);
  assign o_y_valid = (state_q == OUT_HOLD);
  assign o_last    = (state_q == OUT_HOLD) && last_bin;
  assign o_busy    = (state_q != IDLE);
  assign o_y       = y_q;
  assign o_bin     = bin_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_goertzel_multibin.sv
module tb_goertzel_multibin;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_mode, i_coef_we, i_x_valid, i_y_ready;
  logic [3:0]  i_log_n;
  logic [2:0]  i_coef_addr;
  logic [17:0] i_coef_data;
  logic [11:0] i_x;
  logic        o_x_ready, o_y_valid, o_last, o_busy, o_done;
  logic [63:0] o_y;
  logic [2:0]  o_bin;

  always #5 clk = ~clk;

  goertzel_multibin dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_start(i_start), .i_log_n(i_log_n),
    .i_mode(i_mode), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data), .i_x(i_x), .i_x_valid(i_x_valid),
    .o_x_ready(o_x_ready), .o_y(o_y), .o_y_valid(o_y_valid),
    .i_y_ready(i_y_ready), .o_bin(o_bin), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic [63:0] y;
    logic [2:0]  bin;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   samp[8];

  // stall control for the back-pressure check on bin 3
  logic        stall_en = 1'b0;
  int          stall_n  = 0;
  logic [63:0] cap_y;
  logic [2:0]  cap_bin;
  logic        cap_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] y, input int bin);
    exp_t e;
    e.y    = y;
    e.bin  = 3'(bin);
    e.last = (bin == 7);
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_y_valid && q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_y_valid: got o_y_valid=1 bin=%0d, expected no output", o_bin);
      end else if (o_y_valid && i_y_ready) begin
        e = q.pop_front();
        chk("y_value", o_y, e.y);
        chk("y_bin", 64'(o_bin), 64'(e.bin));
        chk("y_last", 64'(o_last), 64'(e.last));
      end
    end
  end

  // Output back-pressure: hold i_y_ready low 5 cycles on bin 3 when enabled.
  initial begin
    i_y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && o_y_valid && o_bin == 3'd3 && stall_n < 5) begin
        if (stall_n == 0) begin
          cap_y = o_y; cap_bin = o_bin; cap_last = o_last;
        end else begin
          chk("stall_y", o_y, cap_y);
          chk("stall_bin", 64'(o_bin), 64'(cap_bin));
          chk("stall_last", 64'(o_last), 64'(cap_last));
        end
        i_y_ready = 1'b0;
        stall_n++;
      end else begin
        i_y_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic wcoef(input int addr, input int data);
    i_coef_we   = 1'b1;
    i_coef_addr = 3'(addr);
    i_coef_data = 18'(data);
    @(posedge clk); #1;
    i_coef_we   = 1'b0;
  endtask

  task automatic run_block(input logic mode, input int logn, input bit disrupt);
    int n, low, lat;
    n = 1 << logn;
    i_mode  = mode;
    i_log_n = 4'(logn);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("start_x_ready", 64'(o_x_ready), 64'd1);
    chk("start_busy", 64'(o_busy), 64'd1);
    i_x_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      i_x = 12'(samp[k]);
      low = 0;
      while (!o_x_ready && low < 100) begin
        low++;
        @(negedge clk);
      end
      if (k > 0) chk("x_ready_low_cycles", 64'(low), 64'd8);
      if (low >= 100) break;
      @(posedge clk); #1;            // sample accepted at this edge
      if (disrupt && k == 0) begin
        i_start = 1'b1; i_coef_we = 1'b1; i_coef_addr = 3'd0; i_coef_data = 18'd0;
        fork
          begin @(posedge clk); #1; i_start = 1'b0; i_coef_we = 1'b0; end
        join_none
      end
      @(negedge clk);
    end
    i_x_valid = 1'b0;
    // last sweep ends 8 cycles after accept; bin 0 valid two cycles later
    lat = 1;
    while (!o_y_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    chk("first_result_latency", 64'(lat), 64'd10);
    low = 0;
    while (o_busy && low < 500) begin
      low++;
      @(negedge clk);
    end
    chk("block_finished", 64'(o_busy), 64'd0);
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_mode = 0; i_coef_we = 0; i_x_valid = 0;
    i_log_n = 0; i_coef_addr = 0; i_coef_data = 0; i_x = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x_ready", 64'(o_x_ready), 64'd0);
    chk("rst_y_valid", 64'(o_y_valid), 64'd0);
    chk("rst_y", o_y, 64'd0);
    chk("rst_bin", 64'(o_bin), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_x_ready", 64'(o_x_ready), 64'd0);
    end
    @(posedge clk); #1;

    // DC, power mode, with mid-block start/coef write that must be ignored
    wcoef(0, 32768);
    for (int b = 1; b < 8; b++) wcoef(b, 0);
    for (int k = 0; k < 8; k++) samp[k] = 100;
    push_exp(64'd640000, 0);
    for (int b = 1; b < 8; b++) push_exp(64'd0, b);
    run_block(1'b0, 3, 1'b1);

    // DC, raw mode, stall on bin 3; coef[0] must still be 2.0
    stall_en = 1'b1; stall_n = 0;
    push_exp({32'd3600, 32'd2800}, 0);
    for (int b = 1; b < 8; b++) push_exp(64'd0, b);
    run_block(1'b1, 3, 1'b0);
    stall_en = 1'b0;
    chk("stall_cycles", 64'(stall_n), 64'd5);

    // Impulse, all coefficients zero
    wcoef(0, 0);
    samp[0] = 1000; samp[1] = 0; samp[2] = 0; samp[3] = 0;
    for (int b = 0; b < 8; b++) push_exp(64'd1000000, b);
    run_block(1'b0, 2, 1'b0);

    // Reset during SWEEP: block discarded, no output
    wcoef(0, 32768);
    i_mode = 1'b0; i_log_n = 4'd3; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_x = 12'd100; i_x_valid = 1'b1;
    @(posedge clk); #1;                 // accepted: now in SWEEP
    i_x_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_y_valid", 64'(o_y_valid), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 64'(o_y_valid), 64'd0);
    end
    @(posedge clk); #1;
    wcoef(0, 32768);
    for (int k = 0; k < 8; k++) samp[k] = 100;
    push_exp(64'd640000, 0);
    for (int b = 1; b < 8; b++) push_exp(64'd0, b);
    run_block(1'b0, 3, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/goertzel_multibin.md
# goertzel_multibin

Time-multiplexed, multi-bin Goertzel engine. It computes the power (or the raw final state pair) of up to NUM_BINS programmable frequency bins over one block of 2^log_n real input samples. It is the parametrised successor to the single-engine Goertzel wrapper, and sits between the sample front end and the spectral post-processing. Per-bin coefficients are loaded through a write port. Results leave as a valid/ready stream, one bin per beat.

## Interface
Parameters:
- WIDTH, 12: signed input sample width.
- ACC_WIDTH, 32: signed Goertzel state width (s1, s2).
- COEF_WIDTH, 18: signed coefficient width; coef = 2·cos(2πk/N) in Q(COEF_WIDTH−FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 14: coefficient fractional bits.
- NUM_BINS, 8: number of bins processed per block (≥2).
- N_MAX, 32768: maximum block length; LOG_N_MAX = $clog2(N_MAX).

Ports:
- i_sys_clk, in, 1: single clock, rising edge.
- i_sys_rst, in, 1: reset; synchronous, active-high.
- i_start, in, 1: start a block; sampled only in IDLE.
- i_log_n, in, $clog2(LOG_N_MAX+1): block length N = 2^i_log_n; values above LOG_N_MAX are clamped to LOG_N_MAX.
- i_mode, in, 1: 0 = power output, 1 = raw state output; latched at start.
- i_coef_we, in, 1: coefficient write strobe; honoured only in IDLE.
- i_coef_addr, in, $clog2(NUM_BINS): bin index to write.
- i_coef_data, in, COEF_WIDTH: coefficient value.
- i_x, in, WIDTH: signed input sample.
- i_x_valid, in, 1: sample valid.
- o_x_ready, out, 1: sample accepted when i_x_valid && o_x_ready.
- o_y, out, 2·ACC_WIDTH: power (mode 0) or {s1, s2} (mode 1).
- o_y_valid, out, 1: result valid.
- i_y_ready, in, 1: result consumed when o_y_valid && i_y_ready.
- o_bin, out, $clog2(NUM_BINS): bin index of o_y.
- o_last, out, 1: asserted with the final bin.
- o_busy, out, 1: high in every state except IDLE.
- o_done, out, 1: one-cycle pulse after the last result handshake.

## Operation
- FSM states: IDLE, ACCUM, SWEEP, OUT_CALC, OUT_HOLD.
- IDLE:
  - A coefficient write updates coef[i_coef_addr] at the clock edge.
  - On i_start: latch the clamped log_n and i_mode, zero every s1/s2 and the sample counter, then go to ACCUM.
  - A write and i_start in the same cycle are both honoured; the new coefficient is used in the block.
- ACCUM: o_x_ready = 1. On handshake, register i_x (sign-extended to ACC_WIDTH), set bin = 0 and go to SWEEP.
- SWEEP: one bin per cycle, bin = 0..NUM_BINS−1.
  - Compute s0 = x + ((coef[b]·s1[b]) >>> FRAC_BITS) − s2[b].
  - Update s2[b] ← s1[b], s1[b] ← s0.
  - After bin NUM_BINS−1, increment the sample count. If count == N, go to OUT_CALC with bin = 0; otherwise return to ACCUM.
- OUT_CALC (1 cycle): load o_y for the current bin, then go to OUT_HOLD.
  - Mode 0: o_y = s1² + s2² − t·s2, where t = (coef·s1) >>> FRAC_BITS truncated to ACC_WIDTH.
  - Mode 1: o_y = {s1, s2}.
- OUT_HOLD: o_y_valid = 1; o_y, o_bin and o_last are held stable until the handshake.
  - On handshake with a non-last bin: bin+1, go to OUT_CALC.
  - On handshake with the last bin: pulse o_done and go to IDLE.
- Arithmetic rules:
  - Products are computed at full precision.
  - >>> is an arithmetic shift (floor).
  - State sums wrap to ACC_WIDTH two's complement; the power sum wraps to 2·ACC_WIDTH; no saturation.
- Ignored inputs:
  - i_start outside IDLE.
  - i_coef_we outside IDLE.
  - i_x_valid outside ACCUM.
- Reset:
  - Any state returns to IDLE.
  - All outputs go to 0: o_x_ready=0, o_y_valid=0, o_y=0, o_bin=0, o_last=0, o_busy=0, o_done=0.
  - Coefficients, states and counters are cleared to 0.
  - Reset mid-block discards the block and produces no output.

## Timing
- i_start in cycle t puts ACCUM in cycle t+1, with o_x_ready=1 and o_busy=1.
- A sample accepted in cycle t updates bin b at the edge ending cycle t+1+b.
- o_x_ready is low for exactly NUM_BINS cycles after each accepted sample. Maximum input rate is one sample per NUM_BINS+1 cycles.
- The last sweep ends in cycle T. o_y_valid for bin 0 rises in cycle T+2.
- Each handshake is followed by one bubble cycle (OUT_CALC) before the next bin is valid. With i_y_ready held high, results arrive every 2 cycles.
- o_done is high the cycle after the last handshake, coincident with IDLE.

## Test plan
- Reset: assert i_sys_rst for 2 cycles, then release. All outputs must read 0 and o_x_ready=0 until i_start.
- DC, mode 0: coef[0]=32768 (2.0), coef[1..7]=0, log_n=3, eight samples x=100.
  - bin0 power must be 640000.
  - bin1 power must be 0.
  - o_last must be set on bin 7 only.
- DC, mode 1: same stimulus. bin0 o_y must be {s1=3600, s2=2800}; bin1 must be {0, 0}.
- Impulse, mode 0: all coef=0, log_n=2, x = 1000, 0, 0, 0. Every bin power must be 1000000.
- Handshakes:
  - Keep i_x_valid constantly high; o_x_ready must be low exactly 8 cycles per sample.
  - Hold i_y_ready low 5 cycles on bin 3; o_y, o_bin and o_last must stay constant.
  - Issue i_start and i_coef_we mid-block; both must be ignored.
- Reset mid-SWEEP: o_busy must go 0 next cycle with no o_y_valid. A fresh DC block afterwards (coefficients reloaded) must reproduce 640000.
